// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_responder
// Purpose  : Byte-level command responder behind a UART. Receives 5-byte
//            request frames (A5 CMD ADDR DATA CHK), executes write/read on a
//            4 x 8-bit register file, and replies with a 4-byte frame
//            (5A STATUS RDATA CHK2) through a start/busy transmitter handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_responder #(
  parameter int TIMEOUT_CYCLES = 6600000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [3:0]  led,
  output logic [31:0] reg_out,
  output logic        err_pulse
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_GET_CMD  = 4'd1,
    ST_GET_ADDR = 4'd2,
    ST_GET_DATA = 4'd3,
    ST_GET_CHK  = 4'd4,
    ST_EXEC     = 4'd5,
    ST_SEND     = 4'd6,
    ST_WAIT_HI  = 4'd7,
    ST_WAIT_LO  = 4'd8
  } state_t;

  state_t           state;
  logic [1:0]       rx_sync;
  logic [1:0]       tx_sync;
  logic             rx_prev;
  logic             byte_evt;
  logic             busy_s;
  logic [CNT_W-1:0] tmo_cnt;
  logic             in_get;
  logic             timeout;
  logic [7:0]       f_cmd;
  logic [7:0]       f_addr;
  logic [7:0]       f_data;
  logic [7:0]       f_chk;
  logic [7:0]       status;
  logic [7:0]       status_r;
  logic [7:0]       rdata_r;
  logic [7:0]       resp_byte;
  logic [1:0]       idx;
  logic [7:0]       regs [4];

  assign busy_s  = tx_sync[1];
  assign in_get  = (state == ST_GET_CMD) || (state == ST_GET_ADDR) ||
                   (state == ST_GET_DATA) || (state == ST_GET_CHK);
  // The counter parks on its last value for exactly one cycle; that cycle is
  // the timeout and it overrides any byte event arriving at the same time.
  assign timeout = in_get && (tmo_cnt == CNT_LAST);
  assign led     = regs[0][3:0];
  assign reg_out = {regs[3], regs[2], regs[1], regs[0]};

  // Cross rx_done/tx_busy into clk and turn the rx_done rise into a byte event
  // one cycle later, so rx_data has settled when it is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync  <= 2'b00;
      tx_sync  <= 2'b00;
      rx_prev  <= 1'b0;
      byte_evt <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rx_done};
      tx_sync  <= {tx_sync[0], tx_busy};
      rx_prev  <= rx_sync[1];
      byte_evt <= rx_sync[1] & ~rx_prev;
    end
  end

  // Inter-byte timer: runs only while collecting a frame, restarts on each byte.
  always_ff @(posedge clk) begin
    if (rst || !in_get || byte_evt || timeout) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Frame status, in priority order: checksum, command, address.
  always_comb begin
    status = 8'h00;
    if (f_chk != (f_cmd ^ f_addr ^ f_data)) begin
      status = 8'h01;
    end else if ((f_cmd != 8'h01) && (f_cmd != 8'h02)) begin
      status = 8'h02;
    end else if (f_addr > 8'h03) begin
      status = 8'h03;
    end
  end

  // Select the response byte for the current transmit index.
  always_comb begin
    case (idx)
      2'd0:    resp_byte = 8'h5A;
      2'd1:    resp_byte = status_r;
      2'd2:    resp_byte = rdata_r;
      default: resp_byte = status_r ^ rdata_r;
    endcase
  end

  // Protocol FSM: frame capture, execute, and per-byte transmit handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      err_pulse <= 1'b0;
      idx       <= 2'd0;
      status_r  <= 8'h00;
      rdata_r   <= 8'h00;
      f_cmd     <= 8'h00;
      f_addr    <= 8'h00;
      f_data    <= 8'h00;
      f_chk     <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      err_pulse <= 1'b0;
      if (timeout) begin
        state     <= ST_IDLE;
        err_pulse <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (byte_evt && (rx_data == 8'hA5)) begin
              state <= ST_GET_CMD;
            end
          end
          ST_GET_CMD: begin
            if (byte_evt) begin
              f_cmd <= rx_data;
              state <= ST_GET_ADDR;
            end
          end
          ST_GET_ADDR: begin
            if (byte_evt) begin
              f_addr <= rx_data;
              state  <= ST_GET_DATA;
            end
          end
          ST_GET_DATA: begin
            if (byte_evt) begin
              f_data <= rx_data;
              state  <= ST_GET_CHK;
            end
          end
          ST_GET_CHK: begin
            if (byte_evt) begin
              f_chk <= rx_data;
              state <= ST_EXEC;
            end
          end
          ST_EXEC: begin
            status_r <= status;
            idx      <= 2'd0;
            state    <= ST_SEND;
            if (status == 8'h00) begin
              if (f_cmd == 8'h01) begin
                regs[f_addr[1:0]] <= f_data;
                rdata_r           <= f_data;
              end else begin
                rdata_r <= regs[f_addr[1:0]];
              end
            end else begin
              rdata_r   <= 8'h00;
              err_pulse <= 1'b1;
            end
          end
          ST_SEND: begin
            tx_data  <= resp_byte;
            tx_start <= 1'b1;
            state    <= ST_WAIT_HI;
          end
          ST_WAIT_HI: begin
            if (busy_s) begin
              tx_start <= 1'b0;
              state    <= ST_WAIT_LO;
            end
          end
          ST_WAIT_LO: begin
            if (!busy_s) begin
              if (idx == 2'd3) begin
                state <= ST_IDLE;
              end else begin
                idx   <= idx + 2'd1;
                state <= ST_SEND;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_responder
// Purpose  : Self-checking bench for uart_cmd_responder: byte-level UART
//            receiver/transmitter models and a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_responder;

  localparam int TMO   = 100;
  localparam int LIMIT = 3000;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  led;
  logic [31:0] reg_out;
  logic        err_pulse;

  int checks    = 0;
  int errors    = 0;
  int err_cnt   = 0;
  int tx_rises  = 0;
  int hold_viol = 0;
  bit slow      = 1'b0;
  bit tx_active = 1'b0;

  logic [7:0] byte_q [$];
  logic [7:0] ref_regs [4];

  logic [7:0] tm_got;
  bit         tm_abort;
  int         tm_d;
  logic [7:0] rc, ra, rdv, rk;
  int         sel, e0, t0, n;

  uart_cmd_responder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .led       (led),
    .reg_out   (reg_out),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  // Count err_pulse cycles.
  always @(negedge clk) begin
    if (err_pulse === 1'b1) err_cnt++;
  end

  // Transmitter model: capture each requested byte, answer with busy after a
  // delay (16x longer in slow mode) and flag any early drop or data change.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx_start === 1'b1) begin
        tx_active = 1'b1;
        tm_got    = tx_data;
        byte_q.push_back(tx_data);
        tx_rises++;
        tm_d     = slow ? 48 : 3;
        tm_abort = 1'b0;
        for (int k = 0; k < tm_d; k++) begin
          @(negedge clk);
          if (rst) begin
            tm_abort = 1'b1;
            break;
          end
          if (tx_start !== 1'b1 || tx_data !== tm_got) hold_viol++;
        end
        if (!tm_abort) begin
          tx_busy = 1'b1;
          repeat (slow ? 96 : 6) @(negedge clk);
          if (tx_start !== 1'b0) hold_viol++;
          tx_busy = 1'b0;
        end
        tx_active = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    repeat (8) @(negedge clk);
    rx_done = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Send optional idle junk plus one request frame, then compare the response,
  // error pulses and register file with the protocol-level expectation.
  task automatic do_frame(input string tag, input int junk,
                          input logic [7:0] cmd, input logic [7:0] addr,
                          input logic [7:0] data, input logic [7:0] chk);
    logic [7:0] st;
    logic [7:0] rd;
    logic [7:0] exp [4];
    int         base_err;
    int         w;
    if (chk != (cmd ^ addr ^ data))       st = 8'h01;
    else if (cmd != 8'h01 && cmd != 8'h02) st = 8'h02;
    else if (addr > 8'h03)                st = 8'h03;
    else                                  st = 8'h00;
    rd = 8'h00;
    if (st == 8'h00) begin
      if (cmd == 8'h01) begin
        ref_regs[addr[1:0]] = data;
        rd = data;
      end else begin
        rd = ref_regs[addr[1:0]];
      end
    end
    exp[0] = 8'h5A; exp[1] = st; exp[2] = rd; exp[3] = st ^ rd;

    base_err = err_cnt;
    byte_q.delete();
    for (int j = 0; j < junk; j++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h3C;
      send_byte(b);
    end
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(addr);
    send_byte(data);
    send_byte(chk);

    w = 0;
    while (!(byte_q.size() >= 4 && !tx_active) && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    repeat (6) @(negedge clk);
    check({tag, ":resp_done"}, 32'(w < LIMIT), 32'd1);
    check({tag, ":resp_len"}, byte_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s:resp%0d", tag, i),
            (byte_q.size() > i) ? {24'h0, byte_q[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
    end
    check({tag, ":err_pulses"}, err_cnt - base_err, 32'(st != 8'h00));
    check({tag, ":reg_out"}, reg_out, {ref_regs[3], ref_regs[2], ref_regs[1], ref_regs[0]});
    check({tag, ":led"}, {28'h0, led}, {28'h0, ref_regs[0][3:0]});
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst:reg_out",   reg_out,             32'h0);
    check("rst:led",       {28'h0, led},        32'h0);
    check("rst:tx_start",  {31'h0, tx_start},   32'h0);
    check("rst:tx_data",   {24'h0, tx_data},    32'h0);
    check("rst:err_pulse", {31'h0, err_pulse},  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed frames
    do_frame("wr_r0", 0, 8'h01, 8'h00, 8'h0F, 8'h0E);
    check("wr_r0:led_F", {28'h0, led}, 32'hF);
    do_frame("rd_r0", 0, 8'h02, 8'h00, 8'h00, 8'h02);
    do_frame("bad_chk", 0, 8'h01, 8'h02, 8'h33, 8'h00);
    check("bad_chk:reg2", {24'h0, reg_out[23:16]}, 32'h0);
    do_frame("bad_addr", 0, 8'h01, 8'h05, 8'h11, 8'h15);
    send_byte(8'h12);
    do_frame("bad_cmd", 0, 8'h07, 8'h00, 8'h00, 8'h07);
    do_frame("a5_as_data", 0, 8'h01, 8'h01, 8'hA5, 8'hA5);

    // Inter-byte timeout
    e0 = err_cnt;
    t0 = tx_rises;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (3 * TMO) @(negedge clk);
    check("tmo:err_pulses", err_cnt - e0, 32'd1);
    check("tmo:no_tx", tx_rises - t0, 32'd0);
    do_frame("after_tmo", 0, 8'h01, 8'h01, 8'h5C, 8'h5C);

    // Randomized frames, some with a slow transmitter
    for (int f = 0; f < 24; f++) begin
      sel = $urandom_range(0, 9);
      rc  = (sel < 4) ? 8'h01 : (sel < 8) ? 8'h02 : 8'($urandom_range(0, 255));
      ra  = 8'($urandom_range(0, 5));
      rdv = 8'($urandom_range(0, 255));
      rk  = rc ^ ra ^ rdv;
      if ($urandom_range(0, 4) == 0) rk = rk ^ 8'($urandom_range(1, 255));
      slow = ($urandom_range(0, 3) == 0);
      do_frame($sformatf("rnd%0d", f), $urandom_range(0, 2), rc, ra, rdv, rk);
    end

    // Reset while waiting for busy on the second response byte
    slow = 1'b1;
    ref_regs[3] = 8'hC3;
    t0 = tx_rises;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'hC3);
    send_byte(8'hC1);
    n = 0;
    while (tx_rises < t0 + 2 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("rstmid:reached", 32'(n < LIMIT), 32'd1);
    check("rstmid:pre_tx_start", {31'h0, tx_start}, 32'd1);
    check("rstmid:pre_reg_out", reg_out, {ref_regs[3], ref_regs[2], ref_regs[1], ref_regs[0]});
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid:tx_start", {31'h0, tx_start}, 32'h0);
    check("rstmid:reg_out",  reg_out,           32'h0);
    check("rstmid:led",      {28'h0, led},      32'h0);
    check("rstmid:tx_data",  {24'h0, tx_data},  32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    t0 = tx_rises;
    repeat (400) @(negedge clk);
    check("rstmid:no_more_tx", tx_rises - t0, 32'd0);
    slow = 1'b0;
    n = 0;
    while (tx_active && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    do_frame("post_rst", 0, 8'h02, 8'h03, 8'h00, 8'h01);

    check("tx_hold_violations", hold_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
